// File: rtl/kpn_pkg.sv
// ---------------------------------------------------------------------------
// kpn_pkg
//   Shared types for the KPN process network (FIFO channels, delay_module and
//   the other process nodes). Every edge of the network carries token_t.
// ---------------------------------------------------------------------------
package kpn_pkg;

  localparam int TOKEN_WIDTH = 16;

  typedef logic [TOKEN_WIDTH-1:0] token_t;

  // Occupancy counter width for a channel of the given depth: it must be able
  // to represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/kpn_fifo_mem.sv
// ---------------------------------------------------------------------------
// kpn_fifo_mem
//   DEPTH x DATA_WIDTH register array backing a KPN FIFO channel.
//   One synchronous write port, one asynchronous (combinational) read port.
//   The array is not reset; the owning channel tracks validity itself.
//
//   clk      in   write clock
//   we_i     in   write enable
//   waddr_i  in   write slot
//   wdata_i  in   write data
//   raddr_i  in   read slot
//   rdata_o  out  contents of raddr_i (combinational)
// ---------------------------------------------------------------------------
module kpn_fifo_mem
  import kpn_pkg::*;
#(
  parameter int DATA_WIDTH = TOKEN_WIDTH,
  parameter int DEPTH      = 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/kpn_fifo_channel.sv
// ---------------------------------------------------------------------------
// kpn_fifo_channel
//   Bounded FIFO edge between two KPN process nodes. Upstream writes with wr,
//   downstream reads with rd; empty/full give the blocking semantics. The
//   popped token is registered on output_1 and held until the next pop.
//   Misuse (write while full without a read, read while empty) is recorded in
//   sticky overflow/underflow flags, cleared only by reset.
//
//   clk        in   clock, posedge
//   reset_n    in   asynchronous active-low reset
//   wr         in   write request
//   entry_1    in   token written when wr=1
//   rd         in   read request
//   output_1   out  last popped token (registered)
//   empty      out  no tokens stored (registered)
//   full       out  DEPTH tokens stored (registered)
//   count      out  tokens stored
//   overflow   out  sticky: a write was dropped
//   underflow  out  sticky: a read found the channel empty
// ---------------------------------------------------------------------------
module kpn_fifo_channel
  import kpn_pkg::*;
#(
  parameter int DATA_WIDTH = TOKEN_WIDTH,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr,
  input  logic [DATA_WIDTH-1:0]   entry_1,
  input  logic                    rd,
  output logic [DATA_WIDTH-1:0]   output_1,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [AW-1:0]         wp_q, wp_d;
  logic [AW-1:0]         rp_q, rp_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  empty_q, full_q;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  push, pop;

  // A full channel still accepts a write when a read frees a slot on the same
  // edge. An empty channel never forwards the incoming token to the reader.
  assign pop  = rd && !empty_q;
  assign push = wr && (!full_q || rd);

  // Storage. When full, wp == rp and both ports address the same slot; the
  // asynchronous read returns the pre-edge contents, so the popped token is
  // captured before the write replaces it.
  kpn_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wp_q),
    .wdata_i (entry_1),
    .raddr_i (rp_q),
    .rdata_o (rdata)
  );

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    count_d = count_q + CW'(push) - CW'(pop);

    // Pointers wrap naturally: DEPTH is a power of two.
    if (push) wp_d = wp_q + AW'(1);
    if (pop) begin
      rp_d  = rp_q + AW'(1);
      out_d = rdata;
    end

    if (wr && full_q && !rd) ovf_d = 1'b1;
    if (rd && empty_q)       unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      out_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      out_q   <= out_d;
      // Status registered from next-state count so it lines up with count_q.
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CNT_FULL);
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign output_1  = out_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_kpn_fifo_channel.sv
module tb_kpn_fifo_channel;

  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr;
  logic [DW-1:0] entry_1;
  logic          rd;
  logic [DW-1:0] output_1;
  logic          empty, full, overflow, underflow;
  logic [3:0]    count;

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard: tokens accepted but not yet popped, plus model of registers.
  logic [DW-1:0] sb[$];
  logic [DW-1:0] m_out;
  logic          m_ovf, m_unf;

  kpn_fifo_channel #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr        (wr),
    .entry_1   (entry_1),
    .rd        (rd),
    .output_1  (output_1),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".output_1"},  32'(output_1),  32'(m_out));
    chk({tag, ".count"},     32'(count),     32'(sb.size()));
    chk({tag, ".empty"},     32'(empty),     32'(sb.size() == 0));
    chk({tag, ".full"},      32'(full),      32'(sb.size() == DEPTH));
    chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  task automatic model_reset();
    sb.delete();
    m_out = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // One clock: drive, let the edge happen, update the model from the
  // pre-edge occupancy, then compare.
  task automatic cyc(input string tag, input logic w, input logic [DW-1:0] d, input logic r);
    int  n;
    bit  do_pop, do_push;
    wr = w; entry_1 = d; rd = r;
    @(posedge clk); #1;
    n       = sb.size();
    do_pop  = r && (n > 0);
    do_push = w && ((n < DEPTH) || r);
    if (w && (n == DEPTH) && !r) m_ovf = 1'b1;
    if (r && (n == 0))           m_unf = 1'b1;
    if (do_pop)  m_out = sb.pop_front();
    if (do_push) sb.push_back(d);
    wr = 1'b0; rd = 1'b0;
    check_all(tag);
  endtask

  // Assert reset between edges, check outputs without waiting for a clock,
  // hold it across one edge, release just after the following edge.
  task automatic async_reset(input string tag);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; wr = 1'b0; rd = 1'b0; entry_1 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    reset_n = 1'b1;

    // Mid-stream asynchronous reset with a non-zero output register.
    cyc("pre", 1'b1, 16'hAAAA, 1'b0);
    cyc("pre", 1'b1, 16'hBBBB, 1'b0);
    cyc("pre", 1'b0, 16'h0000, 1'b1);
    chk("pre.out_nonzero", 32'(output_1), 32'h0000AAAA);
    #2;
    async_reset("arst");

    // Basic order; first push lands on the first edge after release.
    cyc("ord.w", 1'b1, 16'h1111, 1'b0);
    cyc("ord.w", 1'b1, 16'h2222, 1'b0);
    cyc("ord.w", 1'b1, 16'h3333, 1'b0);
    for (int i = 0; i < 3; i++) cyc("ord.r", 1'b0, 16'h0000, 1'b1);
    chk("ord.empty", 32'(empty), 32'd1);

    // Fill, overflow, drain.
    for (int i = 1; i <= DEPTH; i++) cyc("fill", 1'b1, 16'(i), 1'b0);
    chk("fill.count", 32'(count), 32'd8);
    cyc("ovf", 1'b1, 16'hDEAD, 1'b0);
    chk("ovf.flag", 32'(overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) cyc("drain", 1'b0, 16'h0000, 1'b1);
    chk("drain.last", 32'(output_1), 32'h8);

    // Underflow on empty channel holds output.
    cyc("unf", 1'b0, 16'h0000, 1'b1);
    chk("unf.flag", 32'(underflow), 32'd1);

    // Full + simultaneous access, starting from clean flags.
    #2;
    async_reset("arst2");
    for (int i = 1; i <= DEPTH; i++) cyc("fill2", 1'b1, 16'(i), 1'b0);
    cyc("fullrw", 1'b1, 16'hBEEF, 1'b1);
    chk("fullrw.out", 32'(output_1), 32'h1);
    chk("fullrw.ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) cyc("drain2", 1'b0, 16'h0000, 1'b1);
    chk("drain2.beef", 32'(output_1), 32'hBEEF);

    // Empty + simultaneous access: push only, no fall-through.
    cyc("emptyrw", 1'b1, 16'hCAFE, 1'b1);
    chk("emptyrw.unf", 32'(underflow), 32'd1);
    cyc("emptyrw.r", 1'b0, 16'h0000, 1'b1);
    chk("emptyrw.cafe", 32'(output_1), 32'hCAFE);

    // Sustained push/pop at occupancy 3 across several pointer wraps.
    for (int i = 0; i < 3; i++) cyc("wrap.pre", 1'b1, 16'(16'h0100 + i), 1'b0);
    for (int i = 3; i < 23; i++) cyc("wrap", 1'b1, 16'(16'h0100 + i), 1'b1);
    chk("wrap.out", 32'(output_1), 32'h0113);
    for (int i = 0; i < 3; i++) cyc("wrap.drain", 1'b0, 16'h0000, 1'b1);
    chk("wrap.last", 32'(output_1), 32'h0116);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
